// File: rtl/nbit_pipe_addsub_rca_chunk.sv
// rca_chunk: combinational ripple-carry adder for one pipeline chunk.
// Ports:
//   a, b      - chunk operands (WIDTH bits)
//   ci        - carry into bit 0
//   s         - chunk sum
//   co        - carry out of the chunk's top bit
//   c_msb_in  - carry into the chunk's top bit (signed-overflow detection)
module rca_chunk #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [WIDTH:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co       = c[WIDTH];
  assign c_msb_in = c[WIDTH-1];

endmodule

// File: rtl/nbit_pipe_addsub.sv
// nbit_pipe_addsub: pipelined ripple-carry adder/subtractor.
// The WIDTH-bit carry chain is cut into STAGES chunks of CW bits, one
// register stage per chunk; the whole pipe advances or stalls as one unit.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid / in_ready - operand beat handshake
//   a, b, cin, sub      - operands, carry-in (add only), subtract select
//   out_valid/out_ready - result handshake
//   s, cout, ovf        - sum/difference, carry out (1 = no borrow), signed overflow
module nbit_pipe_addsub #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = WIDTH / STAGES;

  // Stage k keeps (k+1)*CW sum bits and WIDTH-(k+1)*CW not-yet-added bits of
  // each operand. Those variable-width fields are packed back to back into
  // flat vectors; sum_off/rem_off give each stage's base offset.
  localparam int unsigned SUMW = CW * STAGES * (STAGES + 1) / 2;
  localparam int unsigned REMW = (STAGES > 1) ? CW * STAGES * (STAGES - 1) / 2 : 1;

  if (WIDTH % STAGES != 0) begin : g_cfg_err
    $error("nbit_pipe_addsub: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
  end

  function automatic int unsigned sum_off(input int unsigned k);
    return CW * k * (k + 1) / 2;
  endfunction

  function automatic int unsigned rem_off(input int unsigned k);
    return CW * (k * (2 * STAGES - 1 - k) / 2);
  endfunction

  logic              en;
  logic [WIDTH-1:0]  b_eff;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [SUMW-1:0]   sum_q;
  logic [REMW-1:0]   ra_q;
  logic [REMW-1:0]   rb_q;
  logic              cm_q;

  assign b_eff    = sub ? ~b : b;
  assign en       = !v_q[STAGES-1] || out_ready;
  assign in_ready = en;

  if (STAGES == 1) begin : g_no_rem
    assign ra_q = '0;
    assign rb_q = '0;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned RW = WIDTH - k * CW;

    logic [RW-1:0]         op_a;
    logic [RW-1:0]         op_b;
    logic                  ci;
    logic                  vin;
    logic [CW-1:0]         ck_s;
    logic                  co;
    logic                  cm;
    logic [(k+1)*CW-1:0]   sum_d;

    if (k == 0) begin : g_head
      assign op_a  = a;
      assign op_b  = b_eff;
      assign ci    = sub | cin;
      assign vin   = in_valid;
      assign sum_d = ck_s;
    end else begin : g_body
      assign op_a  = ra_q[rem_off(k-1) +: RW];
      assign op_b  = rb_q[rem_off(k-1) +: RW];
      assign ci    = c_q[k-1];
      assign vin   = v_q[k-1];
      assign sum_d = {ck_s, sum_q[sum_off(k-1) +: k*CW]};
    end

    rca_chunk #(.WIDTH(CW)) u_chunk (
      .a        (op_a[CW-1:0]),
      .b        (op_b[CW-1:0]),
      .ci       (ci),
      .s        (ck_s),
      .co       (co),
      .c_msb_in (cm)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q[k]                       <= 1'b0;
        c_q[k]                       <= 1'b0;
        sum_q[sum_off(k) +: (k+1)*CW] <= '0;
      end else if (en) begin
        v_q[k]                       <= vin;
        c_q[k]                       <= co;
        sum_q[sum_off(k) +: (k+1)*CW] <= sum_d;
      end
    end

    if (k < STAGES - 1) begin : g_rem
      localparam int unsigned NW = RW - CW;
      always_ff @(posedge clk) begin
        if (rst) begin
          ra_q[rem_off(k) +: NW] <= '0;
          rb_q[rem_off(k) +: NW] <= '0;
        end else if (en) begin
          ra_q[rem_off(k) +: NW] <= op_a[RW-1:CW];
          rb_q[rem_off(k) +: NW] <= op_b[RW-1:CW];
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (rst) begin
          cm_q <= 1'b0;
        end else if (en) begin
          cm_q <= cm;
        end
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign s         = sum_q[sum_off(STAGES-1) +: WIDTH];
  assign cout      = c_q[STAGES-1];
  assign ovf       = cm_q ^ c_q[STAGES-1];

endmodule

// File: tb/tb_nbit_pipe_addsub.sv
// Bench for nbit_pipe_addsub: three instances (8/2, 32/4, 8/1) share the
// handshake stimulus; each has a negedge scoreboard fed by a reference model.
module tb_nbit_pipe_addsub;

  typedef logic [33:0] res_t; // {ovf, cout, s[31:0]}

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, cin, sub;
  logic [7:0]  a8, b8;
  logic [31:0] a32, b32;

  logic        ir_a, ov_a, co_a, of_a;
  logic [7:0]  s_a;
  logic        ir_b, ov_b, co_b, of_b;
  logic [31:0] s_b;
  logic        ir_c, ov_c, co_c, of_c;
  logic [7:0]  s_c;

  nbit_pipe_addsub #(.WIDTH(8), .STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a), .a(a8), .b(b8),
    .cin(cin), .sub(sub), .out_valid(ov_a), .out_ready(out_ready),
    .s(s_a), .cout(co_a), .ovf(of_a));

  nbit_pipe_addsub #(.WIDTH(32), .STAGES(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_b), .a(a32), .b(b32),
    .cin(cin), .sub(sub), .out_valid(ov_b), .out_ready(out_ready),
    .s(s_b), .cout(co_b), .ovf(of_b));

  nbit_pipe_addsub #(.WIDTH(8), .STAGES(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_c), .a(a8), .b(b8),
    .cin(cin), .sub(sub), .out_valid(ov_c), .out_ready(out_ready),
    .s(s_c), .cout(co_c), .ovf(of_c));

  int total = 0;
  int bad   = 0;

  res_t qa[$], qb[$], qc[$];
  logic ha = 1'b0, hb = 1'b0, hc = 1'b0;
  res_t pa, pb, pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic spurious(input string name, input logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s: got result %0h want no result", name, act);
  endtask

  // Width-generic reference: returns {ovf, cout, s}; ovf from operand signs.
  function automatic res_t refm(input int unsigned w, input logic [31:0] ra,
                                input logic [31:0] rb, input logic ci, input logic sb);
    logic [63:0] mask, be, full;
    logic [31:0] sr;
    logic        c, sa, sbe, ss;
    mask = (64'd1 << w) - 64'd1;
    be   = sb ? (~{32'h0, rb}) & mask : {32'h0, rb} & mask;
    full = ({32'h0, ra} & mask) + be + (sb ? 64'd1 : {63'd0, ci});
    sr   = full[31:0] & mask[31:0];
    c    = full[w];
    sa   = ra[w-1];
    sbe  = be[w-1];
    ss   = sr[w-1];
    return {(sa == sbe) && (ss != sa), c, sr};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      ha = 1'b0;
    end else begin
      chk("a_in_ready", 64'(ir_a), 64'(!ov_a || out_ready));
      if (ov_a && !out_ready) begin
        if (ha) chk("a_hold", 64'({of_a, co_a, 24'h0, s_a}), 64'(pa));
        ha = 1'b1;
        pa = {of_a, co_a, 24'h0, s_a};
      end else ha = 1'b0;
      if (ov_a && out_ready) begin
        if (qa.size() == 0) spurious("a_spurious", 64'(s_a));
        else chk("a_result", 64'({of_a, co_a, 24'h0, s_a}), 64'(qa.pop_front()));
      end
      if (in_valid && ir_a) qa.push_back(refm(8, {24'h0, a8}, {24'h0, b8}, cin, sub));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      qb.delete();
      hb = 1'b0;
    end else begin
      chk("b_in_ready", 64'(ir_b), 64'(!ov_b || out_ready));
      if (ov_b && !out_ready) begin
        if (hb) chk("b_hold", 64'({of_b, co_b, s_b}), 64'(pb));
        hb = 1'b1;
        pb = {of_b, co_b, s_b};
      end else hb = 1'b0;
      if (ov_b && out_ready) begin
        if (qb.size() == 0) spurious("b_spurious", 64'(s_b));
        else chk("b_result", 64'({of_b, co_b, s_b}), 64'(qb.pop_front()));
      end
      if (in_valid && ir_b) qb.push_back(refm(32, a32, b32, cin, sub));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      qc.delete();
      hc = 1'b0;
    end else begin
      chk("c_in_ready", 64'(ir_c), 64'(!ov_c || out_ready));
      if (ov_c && !out_ready) begin
        if (hc) chk("c_hold", 64'({of_c, co_c, 24'h0, s_c}), 64'(pc));
        hc = 1'b1;
        pc = {of_c, co_c, 24'h0, s_c};
      end else hc = 1'b0;
      if (ov_c && out_ready) begin
        if (qc.size() == 0) spurious("c_spurious", 64'(s_c));
        else chk("c_result", 64'({of_c, co_c, 24'h0, s_c}), 64'(qc.pop_front()));
      end
      if (in_valid && ir_c) qc.push_back(refm(8, {24'h0, a8}, {24'h0, b8}, cin, sub));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    a8  = 8'($urandom);
    b8  = 8'($urandom);
    a32 = $urandom;
    b32 = $urandom;
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ov_a"}, 64'(ov_a), 64'd0);
    chk({tag, "_s_a"},  64'(s_a), 64'd0);
    chk({tag, "_co_a"}, 64'(co_a), 64'd0);
    chk({tag, "_of_a"}, 64'(of_a), 64'd0);
    chk({tag, "_ir_a"}, 64'(ir_a), 64'd1);
    chk({tag, "_ov_b"}, 64'(ov_b), 64'd0);
    chk({tag, "_s_b"},  64'(s_b), 64'd0);
    chk({tag, "_ov_c"}, 64'(ov_c), 64'd0);
    chk({tag, "_s_c"},  64'(s_c), 64'd0);
    chk({tag, "_ir_c"}, 64'(ir_c), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[11];
    int   lat[3];
    int   first[3], last[3], cnt[3];
    int   n, acc;
    logic took;

    tv[0]  = '{8'h23, 8'h32, 1'b1, 1'b0, 8'h56, 1'b0, 1'b0};
    tv[1]  = '{8'hAB, 8'hBA, 1'b1, 1'b0, 8'h66, 1'b1, 1'b1};
    tv[2]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tv[3]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    tv[4]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    tv[5]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tv[6]  = '{8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
    tv[7]  = '{8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    tv[8]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    tv[9]  = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
    tv[10] = '{8'h7F, 8'h80, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
    a8 = '0; b8 = '0; a32 = '0; b32 = '0;
    tick();
    chk_idle("reset");
    tick();
    rst = 1'b0;

    // Directed vectors, one beat at a time, with per-instance latency.
    for (int i = 0; i < 11; i++) begin
      a8 = tv[i].a; b8 = tv[i].b; cin = tv[i].cin; sub = tv[i].sub;
      a32 = {tv[i].a, tv[i].b, tv[i].a, tv[i].b};
      b32 = {tv[i].b, tv[i].a, tv[i].b, tv[i].a};
      in_valid = 1'b1;
      lat[0] = -1; lat[1] = -1; lat[2] = -1;
      n = 0;
      while ((lat[0] < 0 || lat[1] < 0 || lat[2] < 0) && n < 12) begin
        tick();
        n++;
        in_valid = 1'b0;
        if (ov_a && lat[0] < 0) begin
          lat[0] = n;
          chk($sformatf("tv%0d_s", i),    64'(s_a),  64'(tv[i].s));
          chk($sformatf("tv%0d_cout", i), 64'(co_a), 64'(tv[i].co));
          chk($sformatf("tv%0d_ovf", i),  64'(of_a), 64'(tv[i].ov));
        end
        if (ov_b && lat[1] < 0) lat[1] = n;
        if (ov_c && lat[2] < 0) lat[2] = n;
      end
      chk($sformatf("tv%0d_lat_a", i), 64'(lat[0]), 64'd2);
      chk($sformatf("tv%0d_lat_b", i), 64'(lat[1]), 64'd4);
      chk($sformatf("tv%0d_lat_c", i), 64'(lat[2]), 64'd1);
    end

    // Back-to-back: 16 beats on consecutive cycles.
    for (int j = 0; j < 3; j++) begin first[j] = -1; last[j] = -1; cnt[j] = 0; end
    for (int c = 0; c < 24; c++) begin
      if (c < 16) begin
        in_valid = 1'b1;
        rand_beat();
      end else in_valid = 1'b0;
      tick();
      if (ov_a) begin if (first[0] < 0) first[0] = c + 1; last[0] = c + 1; cnt[0]++; end
      if (ov_b) begin if (first[1] < 0) first[1] = c + 1; last[1] = c + 1; cnt[1]++; end
      if (ov_c) begin if (first[2] < 0) first[2] = c + 1; last[2] = c + 1; cnt[2]++; end
    end
    chk("b2b_first_a", 64'(first[0]), 64'd2);
    chk("b2b_first_b", 64'(first[1]), 64'd4);
    chk("b2b_first_c", 64'(first[2]), 64'd1);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("b2b_cnt%0d", j),  64'(cnt[j]), 64'd16);
      chk($sformatf("b2b_span%0d", j), 64'(last[j] - first[j] + 1), 64'd16);
    end

    // Backpressure: out_ready low for 5 cycles with the pipe full; the
    // source holds each beat until dut_a accepts it.
    in_valid = 1'b1;
    rand_beat();
    acc = 0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 6 && c < 11);
      #1;
      if (c >= 6 && c < 11) chk($sformatf("bp_in_ready_c%0d", c), 64'(ir_a), 64'd0);
      took = in_valid && ir_a;
      tick();
      if (took) begin
        acc++;
        if (acc < 12) rand_beat();
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (6) tick();
    chk("bp_accepted", 64'(acc), 64'd12);
    chk("bp_drain_a", 64'(qa.size()), 64'd0);
    chk("bp_drain_b", 64'(qb.size()), 64'd0);
    chk("bp_drain_c", 64'(qc.size()), 64'd0);

    // Reset with two beats in flight.
    in_valid = 1'b1;
    a8 = 8'h11; b8 = 8'h22; a32 = 32'h1111_1111; b32 = 32'h2222_2222; cin = 1'b0; sub = 1'b0;
    tick();
    a8 = 8'h33; b8 = 8'h44; a32 = 32'h3333_3333; b32 = 32'h4444_4444;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("midrst");
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("post_rst_ov_a%0d", c), 64'(ov_a), 64'd0);
      chk($sformatf("post_rst_ov_b%0d", c), 64'(ov_b), 64'd0);
    end

    chk("end_q_a", 64'(qa.size()), 64'd0);
    chk("end_q_b", 64'(qb.size()), 64'd0);
    chk("end_q_c", 64'(qc.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
